// File: rtl/accum_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB slice first, with valid/ready handshakes.
// Optional signed saturation is compiled in with `define ADDER_SAT_EN.
module accum_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
`ifdef ADDER_SAT_EN
    input  logic             sat_en,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic [IDX_W-1:0] r_idx;
`ifdef ADDER_SAT_EN
    logic             r_sat;
    logic [WIDTH-1:0] w_sat_val;
`endif

    logic             w_accept;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_s_sl;
    logic             w_cout;
    logic             w_ovf;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_a_sl   = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_sl   = r_b[r_idx*CHUNK +: CHUNK];
    assign {w_cout, w_s_sl} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (CHUNK+1)'(r_carry);
    // Carry into the top bit is recovered from the operand and result MSBs.
    assign w_ovf = w_cout ^ (w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_s_sl[CHUNK-1]);
`ifdef ADDER_SAT_EN
    // A wrapped-negative MSB means positive overflow, so clamp to max positive, else max negative.
    assign w_sat_val = {~w_s_sl[CHUNK-1], {(WIDTH-1){w_s_sl[CHUNK-1]}}};
`endif

    // NOTE: operand registers carry no reset; they are only read after being loaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= in1;
            r_b <= sub ? ~in2 : in2;
`ifdef ADDER_SAT_EN
            r_sat <= sat_en;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_carry <= sub;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= w_s_sl;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_ovf   <= w_ovf;
                        r_state <= DONE;
`ifdef ADDER_SAT_EN
                        if (r_sat && w_ovf) r_sum <= w_sat_val;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_accum_adder.sv
// Scoreboard bench for accum_adder: directed corner cases plus random operations vs. an arithmetic model.
// Saturation cases are exercised when ADDER_SAT_EN is defined.
module tb_accum_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, sat_en, out_valid, out_ready, carry, overflow;
    logic [15:0] in1, in2, sum;

    logic        d_in_valid, d_in_ready, d_sub, d_sat_en, d_out_valid, d_out_ready, d_carry, d_overflow;
    logic [15:0] d_in1, d_in2, d_sum;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   hold_req = 0;
    logic mon_en = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    logic [15:0] held_s;
    logic        held_c, held_o;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accum_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .sub(sub),
`ifdef ADDER_SAT_EN
        .sat_en(sat_en),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow)
    );

    accum_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in1(d_in1), .in2(d_in2), .sub(d_sub),
`ifdef ADDER_SAT_EN
        .sat_en(d_sat_en),
`endif
        .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum), .carry(d_carry), .overflow(d_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on whole operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s, input logic sat);
        exp_t e;
        int sa, sbv, r, ua, ub;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = int'(a);
        ub  = int'(b);
        r   = s ? sa - sbv : sa + sbv;
        e.s = r[15:0];
        e.o = (r > 32767) || (r < -32768);
        e.c = s ? (ua >= ub) : (ua + ub > 65535);
`ifdef ADDER_SAT_EN
        if (sat && e.o) e.s = (r > 0) ? 16'h7FFF : 16'h8000;
`else
        if (sat) e.s = e.s;
`endif
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input logic sat,
                         input logic use_exp, input exp_t ex);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout in_ready=0 required=1");
            return;
        end
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        sub = s;
        sat_en = sat;
        e = use_exp ? ex : model(a, b, s, sat);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 16'($urandom);
        in2 = 16'($urandom);
        sub = 1'($urandom);
        sat_en = 1'($urandom);
    endtask

    task automatic issue_exp(input logic [15:0] a, input logic [15:0] b, input logic s, input logic sat,
                             input logic [15:0] es, input logic ec, input logic eo);
        exp_t ex;
        ex.s = es;
        ex.c = ec;
        ex.o = eo;
        ex.acc_cyc = 0;
        issue(a, b, s, sat, 1'b1, ex);
    endtask

    // Consumer drives out_ready first, then the monitor judges the cycle using that same value.
    always @(negedge clk) begin
        if (out_valid && hold_req > 0) begin
            out_ready = 1'b0;
            hold_req--;
        end else begin
            out_ready = ($urandom_range(0, 99) < 60);
        end

        if (mon_en && rst_n) begin
            if (prev_hs) begin
                check("ready_after_handshake", 32'(in_ready), 32'd1);
                check("valid_after_handshake", 32'(out_valid), 32'd0);
            end
            if (out_valid) begin
                check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output sum=%h expected=none", sum);
                    end else begin
                        check("latency", 32'(cyc - sb[0].acc_cyc), 32'(NCH));
                        check("sum", 32'(sum), 32'(sb[0].s));
                        check("carry", 32'(carry), 32'(sb[0].c));
                        check("overflow", 32'(overflow), 32'(sb[0].o));
                    end
                end else begin
                    check("hold_sum", 32'(sum), 32'(held_s));
                    check("hold_carry", 32'(carry), 32'(held_c));
                    check("hold_overflow", 32'(overflow), 32'(held_o));
                end
                held_s = sum;
                held_c = carry;
                held_o = overflow;
                if (out_ready && sb.size() > 0) void'(sb.pop_front());
            end
            prev_hs    = out_valid && out_ready;
            prev_valid = out_valid && !out_ready;
        end else begin
            prev_hs    = 1'b0;
            prev_valid = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    localparam logic [15:0] EDGE_V [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 3) == 0) return EDGE_V[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        exp_t dummy;
        int   w;
        dummy = '{16'h0, 1'b0, 1'b0, 0};
        rst_n = 1'b0;
        in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; sat_en = 1'b0;
        d_in_valid = 1'b0; d_in1 = '0; d_in2 = '0; d_sub = 1'b0; d_sat_en = 1'b0; d_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        issue_exp(16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue_exp(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        issue_exp(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`ifdef ADDER_SAT_EN
        issue_exp(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        issue_exp(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
        issue_exp(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`endif

        // Stall in DONE for three cycles while offering junk operands.
        hold_req = 3;
        issue_exp(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("stall_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in1 = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Reset two cycles into an operation abandons it.
        issue_exp(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_sum", 32'(sum), 32'd0);
        check("midrun_rst_carry", 32'(carry), 32'd0);
        check("midrun_rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        issue_exp(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Single-slice build: result one cycle after accept.
        @(negedge clk);
        d_in_valid = 1'b1; d_in1 = 16'hFFFF; d_in2 = 16'hFFFF; d_sub = 1'b0;
        @(negedge clk);
        d_in_valid = 1'b0; d_in1 = 16'h0; d_in2 = 16'h0;
        check("c16_not_yet_valid", 32'(d_out_valid), 32'd0);
        @(negedge clk);
        check("c16_out_valid", 32'(d_out_valid), 32'd1);
        check("c16_sum", 32'(d_sum), 32'hFFFE);
        check("c16_carry", 32'(d_carry), 32'd1);
        check("c16_overflow", 32'(d_overflow), 32'd0);
        @(negedge clk);
        check("c16_idle_again", 32'(d_in_ready), 32'd1);

        for (int n = 0; n < 60; n++) begin
            issue(pick(), pick(), 1'($urandom), 1'($urandom), 1'b0, dummy);
        end

        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_adder.md
ACCUM_ADDER -- requirements
Module: accum_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH a multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  operand request.
REQ-006 Port in_ready  output  1  block can accept operands.
REQ-007 Port in1  input  WIDTH  first operand.
REQ-008 Port in2  input  WIDTH  second operand.
REQ-009 Port sub  input  1  0 = in1+in2, 1 = in1-in2; sampled with operands.
REQ-010 Port sat_en  input  1  saturate on signed overflow; present only with ADDER_SAT_EN.
REQ-011 Port out_valid  output  1  result available.
REQ-012 Port out_ready  input  1  consumer takes result.
REQ-013 Port sum  output  WIDTH  result.
REQ-014 Port carry  output  1  carry out of MSB (add) / NOT borrow (sub).
REQ-015 Port overflow  output  1  two's-complement signed overflow of result.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE: on in_valid&&in_ready latch in1, sub?~in2:in2, sub, (sat_en); carry register = sub; chunk index = 0; go RUN.
REQ-018 RUN: each cycle add one CHUNK slice, LSB slice first, with carry register in; write slice into sum register, update carry register; after slice NCH-1 go DONE.
REQ-019 Latency SHALL be exactly NCH cycles from accepting edge to first cycle out_valid=1 (CHUNK=WIDTH gives 1).
REQ-020 DONE: hold sum, carry, overflow, out_valid stable until out_ready=1; on that edge go IDLE.
REQ-021 SHALL not accept new operands in RUN or DONE; in_valid there ignored; no same-cycle DONE->accept (throughput one op per NCH+2 cycles minimum).
REQ-022 overflow = carry into MSB XOR carry out of MSB, computed on final slice.
REQ-023 Arithmetic wraps modulo 2^WIDTH; result bit-exact with (in1 ± in2) mod 2^WIDTH.
REQ-024 sum/carry/overflow SHALL retain last result in IDLE until next result is written; only meaningful while out_valid=1.
REQ-025 in1/in2/sub changes after acceptance SHALL not affect the in-flight operation.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state IDLE, sum=0, carry=0, overflow=0, chunk index=0, regardless of state.
REQ-027 Reset mid-RUN or in DONE SHALL abandon the operation; no out_valid for it; in_ready=1 from the first edge after rst_n returns high (also 1 during reset once the reset edge has occurred).
REQ-028 Before the first reset edge outputs are undefined; bench SHALL apply rst_n=0 for at least 2 cycles.

Configuration
REQ-029 Macro ADDER_SAT_EN: when defined, port sat_en exists; if latched sat_en=1 and overflow=1, sum SHALL be 0x7F..F for positive overflow, 0x80..0 for negative overflow; overflow still reports 1; carry unchanged.
REQ-030 Without ADDER_SAT_EN: no sat_en port, no saturation logic; results always wrap.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 Add 0x0001+0xFFFF, sub=0 -> out_valid exactly 4 cycles after accept, sum=0x0000, carry=1, overflow=0.
REQ-032 Add 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1; with ADDER_SAT_EN and sat_en=1 -> sum=0x7FFF, overflow=1.
REQ-033 Sub 0x0005-0x0007 -> sum=0xFFFE, carry=0, overflow=0; sub 0x8000-0x0001 with sat_en=1 (ADDER_SAT_EN) -> sum=0x8000, overflow=1.
REQ-034 Hold out_ready=0 for 3 cycles in DONE while toggling in_valid/in1 -> sum, carry, out_valid stable, in_ready=0, no new op accepted; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 two cycles after accept -> no out_valid, outputs 0, in_ready=1; next op 0x1234+0x1111 -> sum=0x2345.
REQ-036 Build CHUNK=16 -> 0xFFFF+0xFFFF gives out_valid 1 cycle after accept, sum=0xFFFE, carry=1, overflow=0.
